// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for mem_access_unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access size encodings (11 is illegal)
//   state_e                 : store merge FSM states
//   BYTE_W/HALF_W           : lane widths in bits
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    typedef enum logic {IDLE, MERGE} state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline/data-memory bus of the load-store unit.
//   master : drives mem_read, mem_write, addr, st_data, size, ld_unsigned, dm_rdata
//   slave  : drives dm_we, dm_addr, dm_wdata, ld_data, stall, align_err, err_count
interface mem_access_unit_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 32,
    parameter int CNT_W = 8
);
    logic             mem_read;
    logic             mem_write;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] st_data;
    logic [1:0]       size;
    logic             ld_unsigned;
    logic [WIDTH-1:0] dm_rdata;
    logic             dm_we;
    logic [ADDR-1:0]  dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic [WIDTH-1:0] ld_data;
    logic             stall;
    logic             align_err;
    logic [CNT_W-1:0] err_count;
    modport master (
        output mem_read, mem_write, addr, st_data, size, ld_unsigned, dm_rdata,
        input  dm_we, dm_addr, dm_wdata, ld_data, stall, align_err, err_count
    );
    modport slave (
        input  mem_read, mem_write, addr, st_data, size, ld_unsigned, dm_rdata,
        output dm_we, dm_addr, dm_wdata, ld_data, stall, align_err, err_count
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane of a memory word and extends it.
//   rdata_i : raw memory word
//   off_i   : byte offset addr[1:0]
//   size_i  : access size encoding
//   uns_i   : 1 zero-extends, 0 sign-extends
//   data_o  : aligned, extended result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [1:0]       off_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    output logic [WIDTH-1:0] data_o
);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    assign b = rdata_i[{off_i, 3'b000} +: BYTE_W];
    assign h = rdata_i[{off_i[1], 4'b0000} +: HALF_W];
    assign data_o = size_i == SZ_BYTE ? {{(WIDTH-BYTE_W){~uns_i & b[BYTE_W-1]}}, b} :
                    size_i == SZ_HALF ? {{(WIDTH-HALF_W){~uns_i & h[HALF_W-1]}}, h} : rdata_i;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with read-modify-write sub-word stores.
//   clk, rst : clock and synchronous active-low reset
//   bus      : mem_access_unit_if.slave (pipeline request, data memory, status)
//   SUBWORD_EN defined   : byte/half accesses via a 2-cycle IDLE->MERGE store
//   SUBWORD_EN undefined : every access is a word access, no stall, no merge state
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ADDR  = 32,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    mem_access_unit_if.slave bus
);
    logic [1:0]       sz;
    logic             merge;
    logic             access;
    logic             mis;
    logic             store;
    logic             load;
    logic             sub_st;
    logic [WIDTH-1:0] aligned;
    logic [CNT_W-1:0] cnt_q;
    logic [ADDR-1:0]  word_addr;
    assign word_addr = {2'b00, bus.addr[ADDR-1:2]};
`ifdef SUBWORD_EN
    state_e           state_q;
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] merge_d;
    logic [ADDR-1:0]  addr_q;
    assign sz    = bus.size;
    assign merge = state_q == MERGE;
    always_comb begin
        merge_d = bus.dm_rdata;
        if (sz == SZ_BYTE) merge_d[{bus.addr[1:0], 3'b000} +: BYTE_W] = bus.st_data[BYTE_W-1:0];
        else merge_d[{bus.addr[1], 4'b0000} +: HALF_W] = bus.st_data[HALF_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else if (merge) begin
            state_q <= IDLE;
        end else if (sub_st) begin
            state_q <= MERGE;
            merge_q <= merge_d;
            addr_q  <= word_addr;
        end
    end
    assign bus.stall    = rst && sub_st;
    assign bus.dm_addr  = merge ? addr_q : word_addr;
    assign bus.dm_wdata = merge ? merge_q : bus.st_data;
`else
    logic unused_size;
    assign unused_size  = ^bus.size;
    assign sz           = SZ_WORD;
    assign merge        = 1'b0;
    assign bus.stall    = 1'b0;
    assign bus.dm_addr  = word_addr;
    assign bus.dm_wdata = bus.st_data;
`endif
    // The held request is ignored while the merge write is in flight.
    assign access = (bus.mem_read || bus.mem_write) && !merge;
    assign mis    = (sz == SZ_HALF && bus.addr[0]) || (sz == SZ_WORD && bus.addr[1:0] != 2'b00) || sz == 2'b11;
    assign store  = access && !mis && bus.mem_write;
    assign load   = access && !mis && bus.mem_read && !bus.mem_write;
    assign sub_st = store && sz != SZ_WORD;
    assign bus.align_err = access && mis;
    assign bus.dm_we     = rst && (merge || (store && sz == SZ_WORD));
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else if (bus.align_err && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.err_count = cnt_q;
    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .rdata_i (bus.dm_rdata),
        .off_i   (bus.addr[1:0]),
        .size_i  (sz),
        .uns_i   (bus.ld_unsigned),
        .data_o  (aligned)
    );
    assign bus.ld_data = load ? aligned : '0;
endmodule
